// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo: producer/consumer side is the
// master modport, the FIFO itself is the slave.
interface sync_fifo_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic         we;
  logic [W-1:0] wd;
  logic         re;
  logic         clr_err;
  logic [W-1:0] rd;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [N:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output we, wd, re, clr_err,
    input  rd, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  we, wd, re, clr_err,
    output rd, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock 2**N x W FIFO with occupancy count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int AF_TH = 2**N - 2,
  parameter int AE_TH = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  sync_fifo_if.slave bus
);
  localparam int         D       = 2**N;
  localparam logic [N:0] D_V     = D[N:0];
  localparam logic [N:0] AF_V    = AF_TH[N:0];
  localparam logic [N:0] AE_V    = AE_TH[N:0];
  localparam logic [N:0] PTR_ONE = {{N{1'b0}}, 1'b1};

  logic [W-1:0] mem [D];
  logic [N:0]   w_ptr, r_ptr, count_q, count_nxt;
  logic         full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic         wr_acc, rd_acc;

  // Accept decisions use the registered flags, so no combinational path reaches any flag.
  always_comb begin
    wr_acc    = bus.we && !full_q;
    rd_acc    = bus.re && !empty_q;
    count_nxt = count_q;
    if (wr_acc && !rd_acc)
      count_nxt = count_q + PTR_ONE;
    else if (rd_acc && !wr_acc)
      count_nxt = count_q - PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + PTR_ONE;
      if (rd_acc) r_ptr <= r_ptr + PTR_ONE;
      count_q <= count_nxt;
      full_q  <= (count_nxt == D_V);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_V);
      ae_q    <= (count_nxt <= AE_V);
      // A new error event outranks a clear in the same cycle.
      if (bus.we && full_q)  ovf_q <= 1'b1;
      else if (bus.clr_err)  ovf_q <= 1'b0;
      if (bus.re && empty_q) unf_q <= 1'b1;
      else if (bus.clr_err)  unf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr[N-1:0]] <= bus.wd;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd       = mem[r_ptr[N-1:0]];
  assign bus.rd_valid = !empty_q;
`else
  logic [W-1:0] rd_p0;
  logic         vld_p0;

  // Registered read stage: rd holds its value between accepted reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) rd_p0 <= mem[r_ptr[N-1:0]];
    end
  end

  assign bus.rd       = rd_p0;
  assign bus.rd_valid = vld_p0;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo at W=8, N=2 (depth 4), AF_TH=3, AE_TH=1.
module tb_sync_fifo;
  localparam int W = 8;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.W(W), .N(N)) bus ();

  sync_fifo #(.W(W), .N(N), .AF_TH(3), .AE_TH(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model [$];
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word the DUT presents is compared with the oldest expectation.
  always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
    if (reset_n && bus.rd_valid && bus.re) begin
`else
    if (reset_n && bus.rd_valid) begin
`endif
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h expected no word", bus.rd);
      end else begin
        check("rd_data", bus.rd, exp_q.pop_front());
      end
    end
  end

  // Drives one cycle; the model decides acceptance from its own occupancy.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    bit m_full, m_empty;
    m_full  = (model.size() == 4);
    m_empty = (model.size() == 0);
    bus.we = w; bus.wd = d; bus.re = r;
    if (r && !m_empty) exp_q.push_back(model.pop_front());
    if (w && !m_full)  model.push_back(d);
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_ae"},    bus.almost_empty, 1);
    check({tag, "_full"},  bus.full, 0);
    check({tag, "_af"},    bus.almost_full, 0);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_ovf"},   bus.overflow, 0);
    check({tag, "_unf"},   bus.underflow, 0);
    check({tag, "_rdv"},   bus.rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check({tag, "_rd"},    bus.rd, 0);
`endif
  endtask

  initial begin
    logic [7:0] wvals [4];
    int exp_cnt [4];
    int exp_ae  [4];
    int exp_af  [4];
    int exp_fl  [4];
    wvals   = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_cnt = '{1, 2, 3, 4};
    exp_ae  = '{1, 0, 0, 0};
    exp_af  = '{0, 0, 1, 1};
    exp_fl  = '{0, 0, 0, 1};
    bus.we = 0; bus.wd = '0; bus.re = 0; bus.clr_err = 0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");

    // Fill, then overflow with 0x55 which must never be read.
    for (int i = 0; i < 4; i++) begin
      step(1, wvals[i], 0);
      check("fill_count", bus.count, exp_cnt[i]);
      check("fill_ae",    bus.almost_empty, exp_ae[i]);
      check("fill_af",    bus.almost_full, exp_af[i]);
      check("fill_full",  bus.full, exp_fl[i]);
    end
    step(1, 8'h55, 0);
    check("ovf_set",   bus.overflow, 1);
    check("ovf_count", bus.count, 4);
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    step(0, '0, 0);
    check("drain_empty", bus.empty, 1);
    check("drain_count", bus.count, 0);
    step(0, '0, 1);
    check("unf_set", bus.underflow, 1);
    bus.clr_err = 1'b1;
    step(0, '0, 0);
    bus.clr_err = 1'b0;
    check("clr_ovf", bus.overflow, 0);
    check("clr_unf", bus.underflow, 0);

    // Wrap pointers with single write/read rounds.
    for (int i = 0; i < 6; i++) begin
      step(1, 8'hA0 + 8'(i), 0);
      check("wrap_count1", bus.count, 1);
      step(0, '0, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check("wrap_rdv", bus.rd_valid, 1);
      check("wrap_rd",  bus.rd, 8'hA0 + i);
`endif
      check("wrap_empty", bus.empty, 1);
    end
    step(0, '0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("wrap_rdv_drop", bus.rd_valid, 0);
`endif

    // Simultaneous we/re when full, then when empty.
    for (int i = 0; i < 4; i++) step(1, 8'hB0 + 8'(i), 0);
    check("full_before", bus.full, 1);
    step(1, 8'hC0, 1);
    check("fullrw_count", bus.count, 3);
    check("fullrw_ovf",   bus.overflow, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    step(0, '0, 0);
    check("empty_before", bus.empty, 1);
    step(1, 8'hD0, 1);
    check("emptyrw_count", bus.count, 1);
    check("emptyrw_unf",   bus.underflow, 1);
    check("emptyrw_ovf",   bus.overflow, 1);
    bus.clr_err = 1'b1;
    step(0, '0, 0);
    bus.clr_err = 1'b0;
    check("clr2_ovf", bus.overflow, 0);
    check("clr2_unf", bus.underflow, 0);
    step(0, '0, 1);
    step(0, '0, 0);

    // Asynchronous reset between edges with two words stored.
    step(1, 8'h61, 0);
    step(1, 8'h62, 0);
    check("pre_rst_count", bus.count, 2);
    #2 reset_n = 1'b0;
    #1 check_reset_state("async_rst");
    model.delete();
    @(posedge clk); #1;
    check_reset_state("held_rst");
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    step(1, 8'h77, 0);
    check("post_rst_count", bus.count, 1);
    step(0, '0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_rst_rd", bus.rd, 8'h77);
`endif
    repeat (3) step(0, '0, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
